ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Valid/ready FIFO controller wrapped around the 16x8 dual-port RAM (ram_16to8). Drives RAM write and read ports.
//  Absorbs the RAM's 1-cycle registered-read latency with a 2-entry output buffer (first-word-fall-through stream).
//  Sits between a producer stream and a consumer stream. Sustains 1 word/cycle in steady state.
// PARAMETERS
//  WIDTH  8   data width; equals RAM width
//  DEPTH  16  RAM entries; power of two
//  ADDR   4   log2(DEPTH); equals RAM address width
// PORTS
//  clk          in   1        clock; all state on posedge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        producer has data
//  in_ready     out  1        controller accepts data; transfer when in_valid & in_ready
//  in_data      in   WIDTH    producer data
//  out_valid    out  1        out_data holds head word
//  out_ready    in   1        consumer takes head; transfer when out_valid & out_ready
//  out_data     out  WIDTH    head of output buffer
//  level        out  ADDR+2   words held = mem_cnt + rd_pend + out_cnt (max DEPTH+2)
//  ram_we       out  1        RAM write enable
//  ram_wr_addr  out  ADDR     RAM write address = wr_ptr[ADDR-1:0]
//  ram_wr_data  out  WIDTH    = in_data
//  ram_re       out  1        RAM read enable
//  ram_rd_addr  out  ADDR     RAM read address = rd_ptr[ADDR-1:0]
//  ram_d_out    in   WIDTH    RAM registered read data; valid the cycle after ram_re
// BEHAVIOUR
//  - State:
//    - wr_ptr, rd_ptr: ADDR+1 bits; extra bit is the wrap flag.
//    - mem_cnt = wr_ptr - rd_ptr, range 0..DEPTH.
//    - rd_pend: 1 bit, a read is in flight.
//    - obuf[0..1] with out_cnt 0..2; obuf[0] is the head.
//  - Reset (rst=1 at posedge):
//    - wr_ptr = rd_ptr = 0; rd_pend = 0; out_cnt = 0; obuf = 0.
//    - Resulting outputs: out_valid = 0, out_data = 0, level = 0.
//    - While rst is high: in_ready = 0, ram_we = 0, ram_re = 0.
//  - Write path:
//    - in_ready = !rst & (mem_cnt != DEPTH).
//    - ram_we = in_valid & in_ready. On ram_we, wr_ptr increments; wrap is natural mod 2*DEPTH.
//  - Read issue: pop = out_valid & out_ready.
//    - ram_re = !rst & (mem_cnt != 0) & (out_cnt + rd_pend - pop < 2).
//    - On ram_re: rd_ptr increments and rd_pend <= 1; otherwise rd_pend <= 0.
//  - Capture: a cycle with rd_pend = 1 writes ram_d_out into obuf at slot (out_cnt - pop).
//    - pop shifts obuf[1] into obuf[0].
//    - Push and pop in the same cycle leave out_cnt unchanged.
//  - Outputs: out_valid = (out_cnt != 0); out_data = obuf[0], registered and stable while out_valid & !out_ready.
//  - Latency: a word accepted in cycle N is written at end of N, read issued in N+1, captured end of N+2,
//    out_valid in N+3 (when empty and out_ready=1).
//  - Hazards:
//    - Reads only target entries counted in registered mem_cnt.
//    - A write can never hit the address being read in the same cycle; writes are blocked at mem_cnt==DEPTH.
//  - Simultaneous write and read issue at mem_cnt==DEPTH: in_ready stays 0 that cycle (full is evaluated on registered state).
//  - Full: the producer back-pressures at DEPTH words in RAM. Total capacity is DEPTH+2 including obuf.
//  - Empty: no ram_re, out_valid = 0. No underflow is possible.
//  - Reset mid-operation: all stored and in-flight words are discarded. A ram_d_out arriving after reset is ignored.
// TESTING
//  - Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, ram_we=0, out_valid=0, level=0.
//    After release, in_ready=1.
//  - Single word: push 0xA5 at cycle 0, out_ready=1 -> out_valid rises cycle 3 with out_data=0xA5; level returns to 0 after pop.
//  - Fill: out_ready=0, push 0x00..0x13 -> 18 accepted (16 RAM + 2 obuf); in_ready=0 with level=18.
//    Then drain with out_ready=1 -> 0x00..0x11 in order, 1/cycle.
//  - Streaming: in_valid=1 and out_ready=1 continuously for 100 words -> no gaps after the first output; order preserved across pointer wrap.
//  - Random back-pressure: random in_valid/out_ready for 2000 cycles vs a scoreboard queue.
//    -> data match; out_data stable while stalled; level matches the model.
//  - Reset mid-stream: assert rst with level=7 and rd_pend=1 -> next cycle level=0, out_valid=0.
//    Push 0x3C -> output is 0x3C only.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller for a registered-read dual-port RAM, with a 2-entry FWFT output buffer.
// Latency 3 cycles from accept to out_valid when empty; in_ready drops when DEPTH words sit in RAM.
module ram_fifo_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int ADDR  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR+1:0]   level,
   output logic              ram_we,
   output logic [ADDR-1:0]   ram_wr_addr,
   output logic [WIDTH-1:0]  ram_wr_data,
   output logic              ram_re,
   output logic [ADDR-1:0]   ram_rd_addr,
   input  logic [WIDTH-1:0]  ram_d_out
);

   localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

   logic [ADDR:0]     wr_ptr;
   logic [ADDR:0]     rd_ptr;
   logic [ADDR:0]     mem_cnt;
   logic              rd_pend;
   logic [1:0]        out_cnt;
   logic [WIDTH-1:0]  obuf [2];
   logic              pop;
   logic [2:0]        occ_next;
   logic [1:0]        slot;

   assign mem_cnt  = wr_ptr - rd_ptr;
   assign pop      = out_valid & out_ready;
   // Output-buffer occupancy after this cycle's pop and any capture of the in-flight read.
   assign occ_next = {1'b0, out_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign slot     = out_cnt - {1'b0, pop};

   assign in_ready    = !rst && (mem_cnt != FULL_CNT);
   assign ram_we      = in_valid & in_ready;
   assign ram_wr_addr = wr_ptr[ADDR-1:0];
   assign ram_wr_data = in_data;

   // Only issue a read if the word will have a free obuf slot when it lands.
   assign ram_re      = !rst && (mem_cnt != '0) && (occ_next < 3'd2);
   assign ram_rd_addr = rd_ptr[ADDR-1:0];

   assign out_valid = (out_cnt != 2'd0);
   assign out_data  = obuf[0];
   assign level     = (ADDR+2)'(mem_cnt) + (ADDR+2)'(rd_pend) + (ADDR+2)'(out_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_pend <= 1'b0;
         out_cnt <= 2'd0;
         obuf[0] <= '0;
         obuf[1] <= '0;
      end else begin
         if (ram_we) wr_ptr <= wr_ptr + 1'b1;
         if (ram_re) rd_ptr <= rd_ptr + 1'b1;
         rd_pend <= ram_re;
         out_cnt <= occ_next[1:0];
         if (pop) obuf[0] <= obuf[1];
         // Capture overrides the shift when the returning word becomes the new head.
         if (rd_pend) begin
            if (slot == 2'd0) obuf[0] <= ram_d_out;
            else              obuf[1] <= ram_d_out;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and random bench for ram_fifo_ctrl with a behavioural registered-read RAM and a queue scoreboard.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [5:0] level;
   logic       ram_we;
   logic [3:0] ram_wr_addr;
   logic [7:0] ram_wr_data;
   logic       ram_re;
   logic [3:0] ram_rd_addr;
   logic [7:0] ram_d_out;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level),
      .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_d_out(ram_d_out)
   );

   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_re) ram_d_out <= mem[ram_rd_addr];
   end

   int         checks = 0;
   int         failures = 0;
   int         pops = 0;
   logic [7:0] sb [$];
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs after the falling edge, then score the cycle before the next rising edge.
   task automatic step(input logic r, input logic iv, input logic [7:0] id, input logic ordy);
      logic [7:0] exp;
      @(negedge clk);
      rst = r; in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      if (r) begin
         sb.delete();
         stall_prev = 1'b0;
      end else begin
         check("level", 32'(level), 32'(sb.size()));
         if (stall_prev) begin
            check("stall_vld", 32'(out_valid), 32'd1);
            check("stall_dat", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            check("pop_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               check("data", 32'(out_data), 32'(exp));
            end
            pops++;
         end
         if (in_valid && in_ready) sb.push_back(in_data);
         stall_prev = out_valid & !out_ready;
         prev_data  = out_data;
      end
   endtask

   initial begin
      int d;
      int sent;
      int prev;
      int p0;

      // Reset held two cycles with a pushing producer
      step(1'b1, 1'b1, 8'h11, 1'b0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_re", 32'(ram_re), 32'd0);
      step(1'b1, 1'b1, 8'h11, 1'b0);
      check("rst_in_ready2", 32'(in_ready), 32'd0);
      check("rst_we2", 32'(ram_we), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("post_rst_ready", 32'(in_ready), 32'd1);

      // Single word latency
      step(1'b0, 1'b1, 8'hA5, 1'b1);
      check("single_we", 32'(ram_we), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("single_vld1", 32'(out_valid), 32'd0);
      check("single_re1", 32'(ram_re), 32'd1);
      check("single_raddr", 32'(ram_rd_addr), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("single_vld2", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("single_vld3", 32'(out_valid), 32'd1);
      check("single_dat3", 32'(out_data), 32'hA5);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("single_lvl_after", 32'(level), 32'd0);
      check("single_vld_after", 32'(out_valid), 32'd0);

      // Fill with consumer stalled: 16 in RAM plus 2 in the output buffer
      d = 0;
      for (int c = 0; c < 30; c++) begin
         step(1'b0, 1'b1, 8'(d), 1'b0);
         if (in_ready) d++;
      end
      check("fill_accepted", 32'(d), 32'd18);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      check("fill_level", 32'(level), 32'd18);
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1);
         check("drain_vld", 32'(out_valid), 32'd1);
         check("drain_dat", 32'(out_data), 32'(i));
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("drain_empty_vld", 32'(out_valid), 32'd0);
      check("drain_empty_lvl", 32'(level), 32'd0);

      // Continuous streaming across pointer wrap
      sent = 0;
      p0 = pops;
      for (int c = 0; c < 120; c++) begin
         prev = pops - p0;
         step(1'b0, sent < 100, 8'(sent * 3 + 1), 1'b1);
         if (sent < 100) check("stream_rdy", 32'(in_ready), 32'd1);
         if (prev >= 1 && prev < 100) check("stream_no_gap", 32'(out_valid), 32'd1);
         if (in_valid && in_ready) sent++;
      end
      check("stream_count", 32'(pops - p0), 32'd100);

      // Random valid/ready on both sides
      for (int c = 0; c < 2000; c++)
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      for (int c = 0; c < 30; c++)
         step(1'b0, 1'b0, 8'h00, 1'b1);
      check("random_drained", 32'(sb.size()), 32'd0);

      // Reset while a read is in flight with 7 words held
      for (int k = 0; k < 7; k++)
         step(1'b0, 1'b1, 8'(8'h50 + k), 1'b0);
      step(1'b0, 1'b1, 8'h57, 1'b1);
      check("mid_level_pre", 32'(level), 32'd7);
      check("mid_re_pre", 32'(ram_re), 32'd1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check("mid_level_inrst", 32'(level), 32'd7);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("mid_level_post", 32'(level), 32'd0);
      check("mid_vld_post", 32'(out_valid), 32'd0);
      p0 = pops;
      step(1'b0, 1'b1, 8'h3C, 1'b1);
      for (int c = 0; c < 8; c++)
         step(1'b0, 1'b0, 8'h00, 1'b1);
      check("mid_pop_count", 32'(pops - p0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
